viterbi_traceback: RTL

- Consumes the per-stage survivor vectors read back from the survivor memory, newest stage first.
- Walks one pointer chain of `TRACEBACK_DEPTH` stages from a given start state and collects one decoded bit per stage.
- Reverses the bits through an internal LIFO and emits them oldest-first as a valid/ready bit stream.
- Sits between survivor memory readout and the decoded-output formatter.

---
 rtl/viterbi_traceback_pkg.sv | 25 ++
 rtl/tb_bit_lifo.sv | 40 ++++
 rtl/viterbi_traceback.sv | 112 +++++++++++
 3 files changed

// File: rtl/viterbi_traceback_pkg.sv
// Shared constants, types and helpers for the Viterbi traceback block.
package viterbi_traceback_pkg;

    // State index width, survivor vector length and stages per traceback block.
    localparam int unsigned STATE_W  = 8;
    localparam int unsigned N_STATES = 2 ** STATE_W;
    localparam int unsigned DEPTH    = 64;
    localparam int unsigned CNT_W    = $clog2(DEPTH);

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        TRACE,
        OUTPUT
    } tb_state_e;

    // States are laid out as s = {u, p[STATE_W-1:1]}, so the input bit that led
    // into a state is its MSB.
    function automatic logic decoded_bit(input state_t s);
        return s[STATE_W-1];
    endfunction

endpackage

// File: rtl/tb_bit_lifo.sv
// DEPTH x 1-bit storage for traceback bits: one write port, one combinational
// read port. Written newest-stage-first, read back in the opposite order.
module tb_bit_lifo
    import viterbi_traceback_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic we,
    input  cnt_t waddr,
    input  logic wdata,
    input  cnt_t raddr,
    output logic rdata
);

    logic [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0] mem_d;

    // Next-state: update the addressed bit on a write, hold everything else.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage flops with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Combinational read.
    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule

// File: rtl/viterbi_traceback.sv
// Viterbi traceback: chases one survivor-pointer chain of DEPTH stages from a
// start state, then streams the decoded bits oldest-first over valid/ready.
module viterbi_traceback
    import viterbi_traceback_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en_t,
    input  logic                              i_start,
    input  logic [STATE_W-1:0]                i_start_st,
    input  logic                              i_valid,
    input  logic [N_STATES-1:0][STATE_W-1:0]  i_bck_prv_st,
    input  logic                              i_ready,
    output logic                              o_bit,
    output logic                              o_valid,
    output logic                              o_last,
    output logic [STATE_W-1:0]                o_end_st,
    output logic                              o_busy
);

    tb_state_e state_q, state_d;
    state_t    cur_st_q, cur_st_d;
    cnt_t      cnt_q, cnt_d;
    cnt_t      ptr_q, ptr_d;

    logic      lifo_we;
    logic      lifo_wdata;
    logic      lifo_rdata;

    tb_bit_lifo u_lifo (
        .clk   (clk),
        .rst   (rst),
        .we    (lifo_we),
        .waddr (cnt_q),
        .wdata (lifo_wdata),
        .raddr (ptr_q),
        .rdata (lifo_rdata)
    );

    // Next-state logic: FSM, pointer chase, stage counter and output pointer.
    // With en_t low every register keeps its value and the LIFO is not written.
    always_comb begin
        state_d    = state_q;
        cur_st_d   = cur_st_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        lifo_we    = 1'b0;
        lifo_wdata = decoded_bit(cur_st_q);

        if (en_t) begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        cur_st_d = i_start_st;
                        cnt_d    = '0;
                        state_d  = TRACE;
                    end
                end
                TRACE: begin
                    if (i_valid) begin
                        lifo_we  = 1'b1;
                        cur_st_d = i_bck_prv_st[cur_st_q];
                        // Wraps to 0 on the last stage; the count restarts
                        // from 0 anyway on the next start.
                        cnt_d    = cnt_q + cnt_t'(1);
                        if (cnt_q == cnt_t'(DEPTH - 1)) begin
                            ptr_d   = cnt_t'(DEPTH - 1);
                            state_d = OUTPUT;
                        end
                    end
                end
                OUTPUT: begin
                    if (i_ready) begin
                        if (ptr_q == '0) begin
                            state_d = IDLE;
                        end else begin
                            ptr_d = ptr_q - cnt_t'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cur_st_q <= '0;
            cnt_q    <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            cur_st_q <= cur_st_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
        end
    end

    // Outputs depend on registers only; nothing from the inputs leaks through.
    always_comb begin
        o_valid  = (state_q == OUTPUT);
        o_bit    = o_valid & lifo_rdata;
        o_last   = o_valid && (ptr_q == '0);
        o_end_st = o_valid ? cur_st_q : '0;
        o_busy   = (state_q != IDLE);
    end

endmodule
